// File: rtl/shift_seq_ctr.sv
// Parametrised ring/Johnson shift counter with clock enable, synchronous load,
// step index, period-wrap pulse and illegal-state detection/self-correction.
module shift_seq_ctr #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit               AUTOCORR = 1'b1,
  localparam int              SW       = $clog2(2*WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] init_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic [SW-1:0]    step_o,
  output logic             wrap_o,
  output logic             err_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [SW-1:0]    step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] canon;
  logic [WIDTH-2:0] trans;
  logic             ring_ok;
  logic             john_ok;
  logic [SW-1:0]    step_last;

  always_comb begin
    case (mode_i)
      2'b00:   shifted = {count_q[0], count_q[WIDTH-1:1]};
      2'b01:   shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      2'b10:   shifted = {~count_q[0], count_q[WIDTH-1:1]};
      default: shifted = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
    endcase
  end

  // Johnson states have at most one boundary between adjacent differing bits.
  assign trans   = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
  assign john_ok = (trans & (trans - (WIDTH-1)'(1))) == '0;
  assign ring_ok = (count_q != '0) && ((count_q & (count_q - WIDTH'(1))) == '0);
  assign err_o   = mode_i[1] ? ~john_ok : ~ring_ok;

  assign canon     = mode_i[1] ? '0 : WIDTH'(1);
  assign step_last = mode_i[1] ? SW'(2*WIDTH-1) : SW'(WIDTH-1);

  always_comb begin
    count_d = count_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    mode_d  = mode_i;
    if (load_i) begin
      count_d = init_i;
      step_d  = '0;
    end else if (en_i) begin
      if (AUTOCORR && err_o) begin
        count_d = canon;
        step_d  = '0;
      end else if (mode_i != mode_q) begin
        count_d = shifted;
        step_d  = '0;
      end else begin
        count_d = shifted;
        if (step_q == step_last) begin
          step_d = '0;
          wrap_d = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_VAL;
      step_q  <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
    end
  end

  assign count_o = count_q;
  assign step_o  = step_q;
  assign wrap_o  = wrap_q;

endmodule

// File: doc/shift_seq_ctr.md
# shift_seq_ctr

Parametrised ring/Johnson shift counter, generalising the 8-bit ring/Johnson counter in this library. It adds:
- configurable width;
- four run-time modes (ring and Johnson, each rotating left or right);
- clock enable and synchronous load;
- a step index and a sequence-wrap pulse;
- illegal-state detection with optional self-correction.

It is used as a one-hot or Johnson phase sequencer for timing generators and scan/strobe logic.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range is 2 or more.
- `RST_VAL`, default `{{WIDTH-1{1'b0}},1'b1}`: value loaded into `count` on reset.
- `AUTOCORR`, default 1: 1 enables illegal-state self-correction; 0 only flags illegal states.
- `SW`, derived as `$clog2(2*WIDTH)`: width of `step`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  advance enable.
- `load`  in  1  synchronous load of `init`.
- `init`  in  WIDTH  load value.
- `mode`  in  2  sequence select:
  - 00: ring right
  - 01: ring left
  - 10: Johnson right
  - 11: Johnson left
- `count`  out  WIDTH  counter state (registered).
- `step`  out  SW  position within the current period (registered).
- `wrap`  out  1  one-cycle pulse at completion of a full period (registered).
- `err`  out  1  current `count` is illegal for `mode` (combinational).

## Operation
Shift rules (`c` = `count`):
- Ring right: `{c[0], c[W-1:1]}`
- Ring left: `{c[W-2:0], c[W-1]}`
- Johnson right: `{~c[0], c[W-1:1]}`
- Johnson left: `{c[W-2:0], ~c[W-1]}`

Period `P`: WIDTH for ring modes, 2*WIDTH for Johnson modes.

Legality (`err` = 1 when false):
- Ring: exactly one bit set.
- Johnson: `count` is `1^k 0^(WIDTH-k)` or `0^k 1^(WIDTH-k)`, for k = 0..WIDTH.

`mode_q` is an internal register holding `mode` from the previous cycle; it updates every cycle. It resets to 00.

Per-edge priority, highest first:
1. `rst`: `count` = `RST_VAL`, `step` = 0, `wrap` = 0, `mode_q` = 00.
2. `load`: `count` = `init` (illegal values are accepted), `step` = 0, `wrap` = 0. `en` is ignored.
3. `en`=1 with `err`=1 and `AUTOCORR`=1: `count` = canonical start instead of shifting, `step` = 0, `wrap` = 0. Canonical start:
   - ring: `{{WIDTH-1{0}},1}`
   - Johnson: all zeros
4. `en`=1 with `mode` != `mode_q`: shift using the new `mode`, `step` = 0, `wrap` = 0 (the period restarts).
5. `en`=1 otherwise: shift.
   - If `step` == P-1: `step` = 0 and `wrap` = 1.
   - Else: `step` = `step`+1 and `wrap` = 0.
6. `en`=0: `count` and `step` hold; `wrap` = 0.

Additional rules:
- With `AUTOCORR`=0, an illegal state shifts normally and `err` stays asserted; `step` and `wrap` still advance per rule 5.
- `step` arithmetic is modulo P. If the mode changes from Johnson to ring while `step` >= WIDTH, rule 4 clears `step`, so `step` is never >= P.

## Timing
- `count`, `step` and `wrap` change only on the rising edge of `clk`. Latency from `en` to new `count` is 1 cycle.
- `wrap` is high for exactly the one cycle after the edge on which `step` returns from P-1 to 0. It is never high for two consecutive cycles unless P steps elapse, which is impossible for P >= 2.
- `err` follows `count` and `mode` combinationally in the same cycle; it has no register delay.
- A `rst` asserted mid-sequence takes effect on the next edge, regardless of `load`/`en`.
- After reset with the default `RST_VAL` and `mode`=00: `count`=0x01, `step`=0, `wrap`=0, `err`=0.

## Test plan
- **Ring right, WIDTH=8.** Reset, then `en`=1 for 8 cycles. `count` = 0x80, 0x40, 0x20, …, 0x02, 0x01. `step` = 1..7, then 0. `wrap`=1 only in the cycle after the 8th edge.
- **Johnson right.** Load 0x00, `mode`=10, `en`=1 for 16 cycles. `count` = 0x80, 0xC0, …, 0xFF, 0x7F, …, 0x01, 0x00. `wrap` pulses once after the 16th edge.
- **Johnson left and ring left.** From 0x00, Johnson left gives 0x01, 0x03, 0x07. Ring left from 0x01 gives 0x02, 0x04. Toggle `en` low for 3 cycles mid-sequence: `count` and `step` hold and `wrap` stays 0.
- **Self-correction, `AUTOCORR`=1.** Load 0x05 in ring mode: `err`=1. Next `en` edge gives `count`=0x01, `step`=0, `err`=0, `wrap`=0. Load 0x5A in Johnson mode gives `err`=1, then `count`=0x00. With `AUTOCORR`=0, 0x05 rotates right to 0x82 with `err` still 1.
- **Mode change mid-run.** At `step`=5 in Johnson right, switch to ring left. On the next edge `step`=0 and there is no wrap; a `wrap` pulse occurs after 8 further enabled edges.
- **Priority.** Assert `rst`, `load` and `en` together: reset values result. Assert `load` and `en` together with `init`=0x10: `count`=0x10, `step`=0.
